// File: rtl/irq_controller.sv
// Edge-triggered interrupt collector for the processor IRQ input.
// Ack and return-to-user are inferred from the processor fetch address.
module irq_controller #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = 2,
  parameter logic [31:0] XADR    = 32'h80000008
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic [31:0]        InstAdd,
  output logic               IRQ,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StAssert, StService} state_e;

  state_e               state_q, state_d;
  logic                 irq_q, irq_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [NUM_SRC-1:0]   pend_q, pend_d;
  logic                 busy_q, busy_d;
  logic [NUM_SRC-1:0]   src_prev_q;
  logic                 kernel_prev_q;

  logic [NUM_SRC-1:0]   edges, req, clr;
  logic [ID_W-1:0]      sel_id;
  logic                 found;
  logic                 ack;

  assign edges = src_in & ~src_prev_q;
  assign req   = pend_q & irq_mask;
  // Only a user->supervisor transition landing on the handler counts as an ack.
  assign ack   = (state_q == StAssert) && (InstAdd == XADR) && !kernel_prev_q;

  always_comb begin
    sel_id = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (req[k] && !found) begin
        sel_id = ID_W'(k);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    id_d    = id_q;
    busy_d  = busy_q;
    clr     = '0;
    case (state_q)
      StIdle: begin
        irq_d = 1'b0;
        if (|req) begin
          id_d    = sel_id;
          irq_d   = 1'b1;
          state_d = StAssert;
        end
      end
      StAssert: begin
        if (ack) begin
          clr[id_q] = 1'b1;
          irq_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = StService;
        end else if (!irq_mask[id_q]) begin
          irq_d   = 1'b0;
          state_d = StIdle;
        end
      end
      StService: begin
        if (!InstAdd[31]) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        irq_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    // New edges win over a same-cycle ack clear.
    pend_d = (pend_q & ~clr) | edges;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q       <= StIdle;
      irq_q         <= 1'b0;
      id_q          <= '0;
      pend_q        <= '0;
      busy_q        <= 1'b0;
      kernel_prev_q <= 1'b1;
      src_prev_q    <= src_in;
    end else begin
      state_q       <= state_d;
      irq_q         <= irq_d;
      id_q          <= id_d;
      pend_q        <= pend_d;
      busy_q        <= busy_d;
      kernel_prev_q <= InstAdd[31];
      src_prev_q    <= src_in;
    end
  end

  assign IRQ     = irq_q;
  assign irq_id  = id_q;
  assign pending = pend_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_irq_controller;

  localparam logic [31:0] XADR = 32'h80000008;

  logic        clk = 1'b0;
  logic        RESET;
  logic [3:0]  src_in;
  logic [3:0]  irq_mask;
  logic [31:0] InstAdd;
  logic        IRQ;
  logic [1:0]  irq_id;
  logic [3:0]  pending;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Model: 0 = waiting, 1 = requesting, 2 = handler running.
  int         m_phase;
  bit         m_irq;
  int         m_id;
  bit [3:0]   m_pend;
  bit         m_busy;
  bit         m_was_super;
  bit [3:0]   m_last_src;

  irq_controller #(
    .NUM_SRC(4),
    .ID_W   (2),
    .XADR   (XADR)
  ) dut (
    .clk     (clk),
    .RESET   (RESET),
    .src_in  (src_in),
    .irq_mask(irq_mask),
    .InstAdd (InstAdd),
    .IRQ     (IRQ),
    .irq_id  (irq_id),
    .pending (pending),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit [3:0] rose;
    bit [3:0] wanted;
    bit       entered;
    if (RESET) begin
      m_phase = 0; m_irq = 0; m_id = 0; m_pend = 0; m_busy = 0;
      m_was_super = 1; m_last_src = src_in;
      return;
    end
    rose    = src_in & ~m_last_src;
    wanted  = m_pend & irq_mask;
    entered = (InstAdd == XADR) && !m_was_super;
    if (m_phase == 0) begin
      m_irq = 0;
      if (wanted != 0) begin
        for (int k = 3; k >= 0; k--) if (wanted[k]) m_id = k;
        m_irq = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (entered) begin
        m_pend[m_id] = 0; m_irq = 0; m_busy = 1; m_phase = 2;
      end else if (!irq_mask[m_id]) begin
        m_irq = 0; m_phase = 0;
      end
    end else if (!InstAdd[31]) begin
      m_busy = 0; m_phase = 0;
    end
    m_pend      = m_pend | rose;
    m_last_src  = src_in;
    m_was_super = InstAdd[31];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("irq",     {31'd0, IRQ},    {31'd0, m_irq});
    check_eq("irq_id",  {30'd0, irq_id}, m_id);
    check_eq("pending", {28'd0, pending}, {28'd0, m_pend});
    check_eq("busy",    {31'd0, busy},   {31'd0, m_busy});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    RESET = 1; src_in = 4'b0010; irq_mask = 4'hF; InstAdd = 32'h80000000;
    ticks(3);
    RESET = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("held_pend", {28'd0, pending}, 32'h0);
      check_eq("held_irq",  {31'd0, IRQ}, 32'h0);
    end

    // Single request on source 2.
    InstAdd = 32'h000003C0; src_in = 4'b0000; tick();
    src_in = 4'b0100; tick();
    check_eq("single_pend", {28'd0, pending}, 32'h4);
    tick();
    check_eq("single_irq", {31'd0, IRQ}, 32'h1);
    check_eq("single_id",  {30'd0, irq_id}, 32'h2);
    InstAdd = XADR; tick();
    check_eq("ack_irq",  {31'd0, IRQ}, 32'h0);
    check_eq("ack_pend", {28'd0, pending}, 32'h0);
    check_eq("ack_busy", {31'd0, busy}, 32'h1);
    InstAdd = 32'h000003C4; tick();
    check_eq("ret_busy", {31'd0, busy}, 32'h0);

    // Simultaneous edges on sources 1 and 3.
    src_in = 4'b1010; ticks(2);
    check_eq("prio_id_first", {30'd0, irq_id}, 32'h1);
    InstAdd = XADR; tick();
    InstAdd = 32'h000003C4; ticks(2);
    check_eq("prio_irq_second", {31'd0, IRQ}, 32'h1);
    check_eq("prio_id_second",  {30'd0, irq_id}, 32'h3);
    InstAdd = XADR; tick();
    InstAdd = 32'h000003C4; tick();

    // Mask drop while asserting.
    src_in = 4'b0000; tick();
    src_in = 4'b0001; ticks(2);
    irq_mask = 4'b1110; tick();
    check_eq("mask_irq",  {31'd0, IRQ}, 32'h0);
    check_eq("mask_pend", {31'd0, pending[0]}, 32'h1);
    irq_mask = 4'hF; tick();
    check_eq("unmask_irq", {31'd0, IRQ}, 32'h1);
    InstAdd = XADR; tick();
    InstAdd = 32'h000003C4; tick();

    // Supervisor code passing through the handler address is not an ack.
    src_in = 4'b0000; tick();
    src_in = 4'b0001; tick();
    InstAdd = 32'h80000004; ticks(2);
    InstAdd = XADR; ticks(2);
    check_eq("super_irq", {31'd0, IRQ}, 32'h1);
    InstAdd = 32'h000003C0; tick();
    InstAdd = XADR; tick();
    check_eq("super_then_ack", {31'd0, busy}, 32'h1);

    // Re-request during service, then reset while asserting.
    src_in = 4'b0000; tick();
    src_in = 4'b0001; tick();
    check_eq("rereq_pend", {28'd0, pending}, 32'h1);
    tick();
    check_eq("rereq_irq", {31'd0, IRQ}, 32'h0);
    InstAdd = 32'h000003C0; ticks(2);
    check_eq("rereq_raise", {31'd0, IRQ}, 32'h1);
    RESET = 1; tick();
    check_eq("rst_irq",  {31'd0, IRQ}, 32'h0);
    check_eq("rst_pend", {28'd0, pending}, 32'h0);
    RESET = 0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] addrs [4];
      addrs[0] = 32'h000003C0; addrs[1] = XADR;
      addrs[2] = 32'h80000004; addrs[3] = 32'h00000100;
      if ($urandom_range(3) == 0) src_in = src_in ^ (4'(1) << $urandom_range(3));
      if ($urandom_range(15) == 0) irq_mask = 4'($urandom);
      else if ($urandom_range(7) == 0) irq_mask = 4'hF;
      InstAdd = addrs[$urandom_range(3)];
      RESET = ($urandom_range(199) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
